dmem_mmio_responder: RTL
========================

# dmem_mmio_responder

Responder side of the CPU data-memory port. Serves the `dmem_en` / `dmem_we` / `dmem_addr` / `dmem_din` requests driven by the control FSM, and returns `dmem_dout` with single-cycle registered latency, identical to block-RAM port B timing. It backs a 496-word data RAM and maps the top 16 words to board I/O: LEDs, a HEX display register, synchronised switches, and a free-running timer with a sticky wrap flag.

## Interface
Parameters:
- `ADDR_W`, 9: data address width.
- `IO_BASE`, 9'h1F0: first I/O word. RAM occupies 0 .. `IO_BASE`-1.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `dmem_en`  in  1: request valid this cycle.
- `dmem_we`  in  1: 1 = write, 0 = read; ignored when `dmem_en`=0.
- `dmem_addr`  in  `ADDR_W`: word address.
- `dmem_din`  in  16: write data.
- `dmem_dout`  out  16: read data, registered.
- `rd_valid`  out  1: high for exactly the cycle in which `dmem_dout` carries a fresh read result.
- `sw_in`  in  10: asynchronous board switches.
- `led_out`  out  10: LED register.
- `hex_out`  out  16: HEX display register.

## Operation
- Address map:
  - 0x000–0x1EF: RAM, read/write.
  - 0x1F0: LED register. Write stores `dmem_din[9:0]`; read returns `{6'b0, led}`.
  - 0x1F1: HEX register, 16-bit read/write.
  - 0x1F2: switches, read-only; returns `{6'b0, sw_sync}`; writes ignored.
  - 0x1F3: timer. Read returns the count. Write loads `dmem_din`.
  - 0x1F4: status. Read returns `{15'b0, wrap_flag}`. Writing 1 to bit 0 clears the flag.
  - 0x1F5–0x1FF: read returns 0; writes ignored.
- Switches pass through a 2-flop synchroniser; `sw_sync` is the second flop.
- Timer:
  - Increments by 1 every cycle, 16-bit, wrapping 0xFFFF→0x0000.
  - The wrap transition sets `wrap_flag`.
  - A write to 0x1F3 overrides the increment in that cycle and never sets the flag.
- Simultaneous wrap and clear-write to 0x1F4: set wins; the flag stays 1.
- RAM contents are not reset. I/O registers are reset.
- Reset values: `dmem_dout`=0, `rd_valid`=0, `led_out`=0, `hex_out`=0, timer=0, `wrap_flag`=0, synchroniser flops=0.

## Timing
- Read accepted at edge N (`dmem_en`=1, `dmem_we`=0):
  - `dmem_dout` is valid after edge N, i.e. during cycle N+1.
  - `rd_valid`=1 during that same cycle only.
- Register-valued reads (LED, HEX, switches, timer, status) return the value held *before* edge N. A timer read therefore returns the count present in the request cycle.
- Write accepted at edge N:
  - Target is updated at edge N.
  - `dmem_dout` holds its previous value (no-change mode).
  - `rd_valid`=0.
  - A read of the same address issued in cycle N+1 returns the new data.
- No request, or a write: `dmem_dout` holds its last value and `rd_valid`=0.
- Back-to-back reads every cycle are supported. There is no stall and no backpressure.
- Switch change at the pins becomes visible to reads 2 edges later.
- `rst` asserted mid-request:
  - The request is discarded.
  - Next cycle: `rd_valid`=0, `dmem_dout`=0, and registers hold their reset values.
  - RAM contents written before reset persist.
- `dmem_we`, `dmem_addr` and `dmem_din` are don't-care when `dmem_en`=0. They must not alter any state.

## Test plan
- **RAM round trip:** write 0xBEEF to 0x005, then read 0x005 on the next cycle. Expect `dmem_dout`=0xBEEF and `rd_valid`=1 one cycle after the read. `dmem_dout` is unchanged during the write.
- **LED and HEX:** write 0xFFFF to 0x1F0 → `led_out`=0x3FF; reading 0x1F0 returns 0x03FF. Write 0x1234 to 0x1F1 → `hex_out`=0x1234.
- **Switch synchronisation:** set `sw_in`=0x2A5 and read 0x1F2 at edges +1, +2, +3. Expect 0x0000, 0x0000, 0x02A5.
- **Timer wrap:**
  - Write 0xFFFE to 0x1F3. Two edges later the count is 0x0000 and a status read returns 0x0001.
  - Write 1 to 0x1F4, then read status → 0x0000.
  - Issue the clear on the exact wrap cycle → status read returns 0x0001.
- **Unmapped and idle:**
  - Read 0x1F8 → 0x0000 with `rd_valid`=1.
  - Write 0x1F8, then read 0x000 → RAM value is unaffected.
  - Toggle `dmem_addr`/`dmem_din` with `dmem_en`=0 → no state change and `rd_valid` stays 0.
- **Reset mid-operation:**
  - Write LED=0x155 and RAM[0x010]=0x0A0A.
  - Assert `rst` for one cycle together with a read. Afterwards `led_out`=0, `rd_valid`=0, `dmem_dout`=0, and timer=0.
  - Read 0x010 → 0x0A0A.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder
//
// Responder for the CPU data-memory port. Serves a 496-word data RAM plus a
// 16-word I/O window at the top of the address space (LED register, HEX
// display register, synchronised switches, a free-running timer and a sticky
// timer-wrap flag). Read data comes back with one cycle of registered
// latency, matching block-RAM port B timing.
//
// Request handshake: dmem_en is the valid strobe. There is no ready; every
// request with dmem_en=1 is accepted at the rising edge it is presented on.
// dmem_we/dmem_addr/dmem_din are ignored while dmem_en=0. A read accepted at
// edge N is returned on dmem_dout during cycle N+1, flagged by rd_valid=1 for
// that cycle only. Writes and idle cycles leave dmem_dout unchanged.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   dmem_en    request valid
//   dmem_we    1 = write, 0 = read
//   dmem_addr  word address
//   dmem_din   write data
//   dmem_dout  registered read data
//   rd_valid   dmem_dout carries a fresh read result this cycle
//   sw_in      asynchronous board switches
//   led_out    LED register
//   hex_out    HEX display register
// -----------------------------------------------------------------------------
module dmem_mmio_responder #(
  parameter int                ADDR_W  = 9,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'('h1F0)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_en,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [15:0]       dmem_din,
  output logic [15:0]       dmem_dout,
  output logic              rd_valid,
  input  logic [9:0]        sw_in,
  output logic [9:0]        led_out,
  output logic [15:0]       hex_out
);

  localparam int RAM_WORDS = int'(IO_BASE);

  // I/O word offsets relative to IO_BASE
  localparam logic [ADDR_W-1:0] OFF_LED  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_HEX  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_SW   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_TMR  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(4);

  logic [15:0]       ram [0:RAM_WORDS-1];

  logic [9:0]        sw_meta;
  logic [9:0]        sw_sync;
  logic [15:0]       timer;
  logic              wrap_flag;

  logic              wr_req;
  logic              rd_req;
  logic              is_ram;
  logic [ADDR_W-1:0] io_off;
  logic              sel_led, sel_hex, sel_sw, sel_tmr, sel_stat;
  logic              timer_wrap;
  logic [15:0]       rd_data;

  // Address decode and read mux; register reads see pre-edge values.
  always_comb begin
    wr_req     = dmem_en & dmem_we;
    rd_req     = dmem_en & ~dmem_we;
    is_ram     = (dmem_addr < IO_BASE);
    io_off     = dmem_addr - IO_BASE;
    sel_led    = !is_ram && (io_off == OFF_LED);
    sel_hex    = !is_ram && (io_off == OFF_HEX);
    sel_sw     = !is_ram && (io_off == OFF_SW);
    sel_tmr    = !is_ram && (io_off == OFF_TMR);
    sel_stat   = !is_ram && (io_off == OFF_STAT);
    // A timer load in the same cycle replaces the increment, so it can never
    // produce a wrap event.
    timer_wrap = !(wr_req && sel_tmr) && (timer == 16'hFFFF);

    rd_data = 16'h0000;
    if (is_ram)        rd_data = ram[dmem_addr];
    else if (sel_led)  rd_data = {6'b0, led_out};
    else if (sel_hex)  rd_data = hex_out;
    else if (sel_sw)   rd_data = {6'b0, sw_sync};
    else if (sel_tmr)  rd_data = timer;
    else if (sel_stat) rd_data = {15'b0, wrap_flag};
  end

  // RAM array: no reset so it maps onto block RAM and survives rst. A write
  // presented together with rst is discarded like any other request.
  always_ff @(posedge clk) begin
    if (!rst && wr_req && is_ram) begin
      ram[dmem_addr] <= dmem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      led_out   <= '0;
      hex_out   <= '0;
      timer     <= '0;
      wrap_flag <= 1'b0;
      dmem_dout <= '0;
      rd_valid  <= 1'b0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;

      rd_valid <= rd_req;
      if (rd_req) dmem_dout <= rd_data;

      if (wr_req && sel_led) led_out <= dmem_din[9:0];
      if (wr_req && sel_hex) hex_out <= dmem_din;

      if (wr_req && sel_tmr) timer <= dmem_din;
      else                   timer <= timer + 16'd1;

      // Set has priority over a simultaneous write-1-to-clear.
      if (timer_wrap)                              wrap_flag <= 1'b1;
      else if (wr_req && sel_stat && dmem_din[0])  wrap_flag <= 1'b0;
    end
  end

endmodule
